jtkicker_vtimer: RTL and testbench
==================================

# jtkicker_vtimer

Video timing generator for the Kicker core. It consumes the ~6.144 MHz pixel clock enable (pxl_cen) produced by the core's clock-enable block in the 48 MHz domain. It produces pixel/line counters, blanking, syncs and the vertical-blank CPU interrupt request for the tilemap, sprite and CPU blocks. All outputs are registered and advance only on pxl_cen cycles.

## Interface
- HTOTAL, 384: pixels per line; hdump counts 0..HTOTAL-1.
- VTOTAL, 264: lines per frame; vdump counts 0..VTOTAL-1.
- HB_START, 256: first horizontally blanked pixel. The blank region is [HB_START, HTOTAL).
- HS_START, 296 / HS_END, 328: hsync active for hdump in [HS_START, HS_END).
- VB_START, 240 / VB_END, 16: vertical blank for vdump >= VB_START or vdump < VB_END.
- VS_START, 248 / VS_END, 256: vsync active for vdump in [VS_START, VS_END).
- clk  in  1  48 MHz video clock (49.152 MHz with the 6144 PLL).
- rst  in  1  Reset, synchronous, active-high.
- pxl_cen  in  1  Pixel clock enable, one clk wide.
- irq_en  in  1  CPU interrupt enable latch. Low clears and masks irq.
- hdump  out  9  Horizontal pixel counter.
- vdump  out  9  Line counter.
- LHBL  out  1  Horizontal blank, active low (1 = visible).
- LVBL  out  1  Vertical blank, active low.
- HS  out  1  Horizontal sync, active high.
- VS  out  1  Vertical sync, active high.
- irq  out  1  Vertical-blank interrupt request, level, active high.

## Operation
- Counters
  - On pxl_cen, hdump increments. When hdump is HTOTAL-1, it wraps to 0 and vdump advances.
  - vdump wraps from VTOTAL-1 to 0.
- Flags
  - LHBL, LVBL, HS and VS are decoded from the next counter values and registered in the same cycle as the counters. A flag therefore always matches the hdump/vdump pair visible on the same clk.
  - LHBL = hdump < HB_START.
  - LVBL = !(vdump >= VB_START || vdump < VB_END).
  - HS and VS follow the half-open ranges above.
- Interrupt
  - irq sets on the pxl_cen cycle where LVBL goes 1→0 (vdump becomes VB_START at hdump 0), but only if irq_en=1.
  - irq stays high until irq_en=0. Clearing takes effect on the next clk, independent of pxl_cen.
  - If a set and a clear happen in the same cycle, the clear wins.
  - When irq_en is raised again, irq does not re-assert until the next vblank start.
- Reset
  - hdump=0, vdump=0, LHBL=0, LVBL=0, HS=0, VS=0, irq=0.
  - The first pxl_cen after reset release loads hdump=1, vdump=0 with consistently decoded flags.
  - Reset mid-frame aborts the frame immediately. There is no partial-line completion.
- Without pxl_cen, all outputs hold (except the irq clear).
- Parameter legality, checked by a simulation-only assertion:
  - HB_START < HTOTAL.
  - HS_START < HS_END <= HTOTAL.
  - VB_END < VB_START < VTOTAL.
  - VS_START < VS_END <= VTOTAL.
  - HTOTAL, VTOTAL <= 512.

## Timing
- Latency:
  - Counters and flags: 1 clk from the pxl_cen cycle.
  - irq set: 1 clk after the qualifying pxl_cen.
  - irq clear: 1 clk after irq_en falls.
- Line period is HTOTAL pxl_cen pulses; frame period is HTOTAL·VTOTAL pulses.
  - 101376 pulses with the defaults.
  - 60.6 Hz at 6.144 MHz; 59.2 Hz at 6.0 MHz.
- The counters use no fractional or pxl2_cen input. A change of pxl_cen rate (the 60 Hz option) only changes the wall-clock period.
- Wrap cycle: hdump HTOTAL-1→0 and the vdump change land in the same clk. There is never an intermediate state.

## Structure
- A shared package jtkicker_pkg holds the default timing constants (the HTOTAL..VS_END values above) so the video blocks and the bench use a single source.
- No sub-module: two counters, a flag decoder and the irq latch stay inline (~150 lines).
- The 9-bit width is a localparam derived from the package constants.

## Test plan
1. rst high 10 clk, then pxl_cen every 8 clk. Required sequence:
   - During reset: all outputs 0.
   - First pulse: hdump=1, vdump=0, LHBL=1, LVBL=0.
2. Run one line:
   - LHBL falls on hdump=256; HS high for hdump 296..327.
   - At hdump=383→0, vdump=1 in the same clk.
3. Run one frame:
   - LVBL high for vdump 16..239.
   - VS high for vdump 248..255.
   - vdump wraps 263→0 after 101376 pulses.
4. irq_en=1 at frame start:
   - irq rises 1 clk after the pulse making vdump=240, hdump=0.
   - irq_en drops at vdump=250: irq=0 next clk.
   - irq_en raised at 252: irq stays 0 until the next vdump=240.
5. Clear priority: irq_en falls on the same clk as the vblank-start pulse → irq stays 0.
6. Pulse rst at vdump=100, hdump=50:
   - Next clk: all outputs at reset values.
   - Counting restarts as in scenario 1.

Source files
------------

// File: rtl/jtkicker_pkg.sv
// Default Kicker video timing constants shared by the video blocks and their bench.
package jtkicker_pkg;

  localparam int HTOTAL   = 384;
  localparam int VTOTAL   = 264;
  localparam int HB_START = 256;
  localparam int HS_START = 296;
  localparam int HS_END   = 328;
  localparam int VB_START = 240;
  localparam int VB_END   = 16;
  localparam int VS_START = 248;
  localparam int VS_END   = 256;

  // Counter width large enough for the longer of the two default periods.
  localparam int VT_CW = $clog2((HTOTAL > VTOTAL) ? HTOTAL : VTOTAL);

endpackage

// File: rtl/jtkicker_vtimer_if.sv
// Video timing bundle between the timer (master) and its consumers (slave).
interface jtkicker_vtimer_if import jtkicker_pkg::*; ();

  // pxl_cen is a one-clk strobe with no back-pressure; every output is a
  // registered level that changes only on a pxl_cen clk (irq also on irq_en low).
  logic              pxl_cen;
  logic              irq_en;
  logic [VT_CW-1:0]  hdump;
  logic [VT_CW-1:0]  vdump;
  logic              LHBL;
  logic              LVBL;
  logic              HS;
  logic              VS;
  logic              irq;

  modport master (
    input  pxl_cen, irq_en,
    output hdump, vdump, LHBL, LVBL, HS, VS, irq
  );

  modport slave (
    output pxl_cen, irq_en,
    input  hdump, vdump, LHBL, LVBL, HS, VS, irq
  );

endinterface

// File: rtl/jtkicker_vtimer.sv
// Kicker video timing: pixel/line counters, blanking, syncs and the vblank irq latch.
module jtkicker_vtimer #(
  parameter int HTOTAL   = jtkicker_pkg::HTOTAL,
  parameter int VTOTAL   = jtkicker_pkg::VTOTAL,
  parameter int HB_START = jtkicker_pkg::HB_START,
  parameter int HS_START = jtkicker_pkg::HS_START,
  parameter int HS_END   = jtkicker_pkg::HS_END,
  parameter int VB_START = jtkicker_pkg::VB_START,
  parameter int VB_END   = jtkicker_pkg::VB_END,
  parameter int VS_START = jtkicker_pkg::VS_START,
  parameter int VS_END   = jtkicker_pkg::VS_END
) (
  input  logic              clk,
  input  logic              rst,
  jtkicker_vtimer_if.master vif
);

  localparam int CW = jtkicker_pkg::VT_CW;

  localparam bit PARAMS_OK =
    (HB_START < HTOTAL) &&
    (HS_START < HS_END) && (HS_END <= HTOTAL) &&
    (VB_END < VB_START) && (VB_START < VTOTAL) &&
    (VS_START < VS_END) && (VS_END <= VTOTAL) &&
    (HTOTAL <= 512) && (VTOTAL <= 512);

  logic [CW-1:0] r_hdump, r_vdump;
  logic          r_lhbl, r_lvbl, r_hs, r_vs, r_irq;

  logic [CW-1:0] w_hdump_nxt, w_vdump_nxt;
  logic          w_h_last;
  logic          w_lhbl_nxt, w_lvbl_nxt, w_hs_nxt, w_vs_nxt;
  logic          w_irq_set;

  // Flags decode the next counter values so they land together with the counters.
  always_comb begin
    w_h_last    = (32'(r_hdump) == HTOTAL - 1);
    w_hdump_nxt = w_h_last ? '0 : r_hdump + 1'b1;
    w_vdump_nxt = r_vdump;
    if (w_h_last) begin
      w_vdump_nxt = (32'(r_vdump) == VTOTAL - 1) ? '0 : r_vdump + 1'b1;
    end
    w_lhbl_nxt = (32'(w_hdump_nxt) < HB_START);
    w_lvbl_nxt = !((32'(w_vdump_nxt) >= VB_START) || (32'(w_vdump_nxt) < VB_END));
    w_hs_nxt   = (32'(w_hdump_nxt) >= HS_START) && (32'(w_hdump_nxt) < HS_END);
    w_vs_nxt   = (32'(w_vdump_nxt) >= VS_START) && (32'(w_vdump_nxt) < VS_END);
    w_irq_set  = vif.pxl_cen && r_lvbl && !w_lvbl_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_hdump <= '0;
      r_vdump <= '0;
      r_lhbl  <= 1'b0;
      r_lvbl  <= 1'b0;
      r_hs    <= 1'b0;
      r_vs    <= 1'b0;
      r_irq   <= 1'b0;
    end else begin
      if (vif.pxl_cen) begin
        r_hdump <= w_hdump_nxt;
        r_vdump <= w_vdump_nxt;
        r_lhbl  <= w_lhbl_nxt;
        r_lvbl  <= w_lvbl_nxt;
        r_hs    <= w_hs_nxt;
        r_vs    <= w_vs_nxt;
      end
      // A low enable clears regardless of pxl_cen and beats a same-cycle set.
      if (!vif.irq_en) begin
        r_irq <= 1'b0;
      end else if (w_irq_set) begin
        r_irq <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    assert (PARAMS_OK) else $error("jtkicker_vtimer: illegal timing parameters");
  end

  assign vif.hdump = r_hdump;
  assign vif.vdump = r_vdump;
  assign vif.LHBL  = r_lhbl;
  assign vif.LVBL  = r_lvbl;
  assign vif.HS    = r_hs;
  assign vif.VS    = r_vs;
  assign vif.irq   = r_irq;

endmodule

// File: tb/tb_jtkicker_vtimer.sv
// Bench for jtkicker_vtimer: default-timing and shrunken-timing instances against a pulse-count model.
module tb_jtkicker_vtimer;
  import jtkicker_pkg::*;

  localparam int S_HT  = 24;
  localparam int S_HB  = 16;
  localparam int S_HSS = 18;
  localparam int S_HSE = 21;
  localparam int S_VT  = 20;
  localparam int S_VBS = 15;
  localparam int S_VBE = 2;
  localparam int S_VSS = 16;
  localparam int S_VSE = 18;

  typedef struct {
    int ht, hb, hss, hse, vt, vbs, vbe, vss, vse;
  } tcfg_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic cen = 1'b0;
  logic irq_en = 1'b0;

  always #5 clk = ~clk;

  jtkicker_vtimer_if vif_d ();
  jtkicker_vtimer_if vif_s ();

  assign vif_d.pxl_cen = cen;
  assign vif_d.irq_en  = irq_en;
  assign vif_s.pxl_cen = cen;
  assign vif_s.irq_en  = irq_en;

  jtkicker_vtimer u_dut_d (
    .clk (clk),
    .rst (rst),
    .vif (vif_d.master)
  );

  jtkicker_vtimer #(
    .HTOTAL(S_HT), .VTOTAL(S_VT), .HB_START(S_HB), .HS_START(S_HSS), .HS_END(S_HSE),
    .VB_START(S_VBS), .VB_END(S_VBE), .VS_START(S_VSS), .VS_END(S_VSE)
  ) u_dut_s (
    .clk (clk),
    .rst (rst),
    .vif (vif_s.master)
  );

  // Reference: pulses since reset (mod frame) fully determine position and flags.
  tcfg_t cfg [2];
  int    n [2];
  bit    started [2];
  bit    irq_m [2];
  int    tests = 0;
  int    fails = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int cur_h(input int k);
    return n[k] % cfg[k].ht;
  endfunction

  function automatic int cur_v(input int k);
    return n[k] / cfg[k].ht;
  endfunction

  task automatic model_update();
    bit set;
    for (int k = 0; k < 2; k++) begin
      if (rst) begin
        n[k] = 0;
        started[k] = 1'b0;
        irq_m[k] = 1'b0;
      end else begin
        set = 1'b0;
        if (cen) begin
          n[k] = (n[k] + 1) % (cfg[k].ht * cfg[k].vt);
          started[k] = 1'b1;
          if (cur_v(k) == cfg[k].vbs && cur_h(k) == 0 && irq_en) set = 1'b1;
        end
        if (!irq_en) irq_m[k] = 1'b0;
        else if (set) irq_m[k] = 1'b1;
      end
    end
  endtask

  task automatic check_dut(input string nm, input int k, input logic [8:0] h, input logic [8:0] v,
                           input logic lhbl, input logic lvbl, input logic hs, input logic vs,
                           input logic irq);
    int eh, ev;
    logic e_lhbl, e_lvbl, e_hs, e_vs;
    eh = 0; ev = 0; e_lhbl = 0; e_lvbl = 0; e_hs = 0; e_vs = 0;
    if (started[k]) begin
      eh = cur_h(k);
      ev = cur_v(k);
      e_lhbl = eh < cfg[k].hb;
      e_lvbl = !(ev >= cfg[k].vbs || ev < cfg[k].vbe);
      e_hs = eh >= cfg[k].hss && eh < cfg[k].hse;
      e_vs = ev >= cfg[k].vss && ev < cfg[k].vse;
    end
    chk({nm, ".hdump"}, 32'(h), eh);
    chk({nm, ".vdump"}, 32'(v), ev);
    chk({nm, ".LHBL"}, 32'(lhbl), 32'(e_lhbl));
    chk({nm, ".LVBL"}, 32'(lvbl), 32'(e_lvbl));
    chk({nm, ".HS"}, 32'(hs), 32'(e_hs));
    chk({nm, ".VS"}, 32'(vs), 32'(e_vs));
    chk({nm, ".irq"}, 32'(irq), 32'(irq_m[k]));
  endtask

  task automatic check_all();
    check_dut("def", 0, vif_d.hdump, vif_d.vdump, vif_d.LHBL, vif_d.LVBL, vif_d.HS, vif_d.VS, vif_d.irq);
    check_dut("sml", 1, vif_s.hdump, vif_s.vdump, vif_s.LHBL, vif_s.LVBL, vif_s.HS, vif_s.VS, vif_s.irq);
  endtask

  task automatic tick(input logic c);
    cen = c;
    @(posedge clk);
    model_update();
    @(negedge clk);
    check_all();
  endtask

  // Issue pulses (optionally with random idle gaps) until instance k sits at (v, h).
  task automatic run_to(input int k, input int v, input int h, input bit gaps);
    int guard;
    guard = 0;
    while (!(cur_v(k) == v && cur_h(k) == h) && guard < 200000) begin
      if (gaps) repeat ($urandom_range(0, 2)) tick(1'b0);
      tick(1'b1);
      guard++;
    end
    tests++;
    assert (guard < 200000) else begin
      fails++;
      $error("FAIL run_to: observed guard %0d, expected below 200000", guard);
    end
  endtask

  task automatic slow_start(input string nm);
    tick(1'b1);
    chk({nm, ".first_h_def"}, 32'(vif_d.hdump), 1);
    chk({nm, ".first_v_def"}, 32'(vif_d.vdump), 0);
    chk({nm, ".first_lhbl_def"}, 32'(vif_d.LHBL), 1);
    chk({nm, ".first_lvbl_def"}, 32'(vif_d.LVBL), 0);
    chk({nm, ".first_h_sml"}, 32'(vif_s.hdump), 1);
    repeat (7) tick(1'b0);
    repeat (3) begin
      tick(1'b1);
      repeat (7) tick(1'b0);
    end
  endtask

  initial begin
    int p;
    cfg[0] = '{HTOTAL, HB_START, HS_START, HS_END, VTOTAL, VB_START, VB_END, VS_START, VS_END};
    cfg[1] = '{S_HT, S_HB, S_HSS, S_HSE, S_VT, S_VBS, S_VBE, S_VSS, S_VSE};
    for (int k = 0; k < 2; k++) begin
      n[k] = 0; started[k] = 1'b0; irq_m[k] = 1'b0;
    end

    // Reset held with pulses arriving; everything stays at zero.
    repeat (10) tick($urandom_range(0, 1) == 1);
    chk("reset.hdump", 32'(vif_d.hdump), 0);
    chk("reset.LHBL", 32'(vif_d.LHBL), 0);
    rst = 1'b0;
    tick(1'b0);
    slow_start("boot");

    // One default line: blank, sync edges and the line wrap.
    run_to(0, 0, 255, 1'b1);
    tick(1'b1);
    chk("line.lhbl_fall_h", 32'(vif_d.hdump), 256);
    chk("line.lhbl_fall", 32'(vif_d.LHBL), 0);
    run_to(0, 0, 295, 1'b1);
    chk("line.hs_before", 32'(vif_d.HS), 0);
    tick(1'b1);
    chk("line.hs_rise", 32'(vif_d.HS), 1);
    run_to(0, 0, 327, 1'b1);
    tick(1'b1);
    chk("line.hs_fall", 32'(vif_d.HS), 0);
    run_to(0, 0, 383, 1'b1);
    tick(1'b1);
    chk("line.wrap_h", 32'(vif_d.hdump), 0);
    chk("line.wrap_v", 32'(vif_d.vdump), 1);
    p = 0;
    do begin
      tick(1'b1);
      p++;
    end while (vif_d.hdump != 9'd0 && p < 2000);
    chk("line.period", p, HTOTAL);

    // Full shrunken frame: period measured from DUT outputs.
    run_to(1, 0, 0, 1'b1);
    p = 0;
    do begin
      tick(1'b1);
      p++;
    end while (!(vif_s.vdump == 9'd0 && vif_s.hdump == 9'd0) && p < 2000);
    chk("frame.period", p, S_HT * S_VT);
    run_to(1, S_VBE - 1, S_HT - 1, 1'b1);
    tick(1'b1);
    chk("frame.lvbl_rise", 32'(vif_s.LVBL), 1);

    // Interrupt: set at vblank start, clear on enable low, no re-set until next vblank.
    run_to(1, 0, 0, 1'b1);
    irq_en = 1'b1;
    run_to(1, S_VBS - 1, S_HT - 1, 1'b1);
    chk("irq.before_vb", 32'(vif_s.irq), 0);
    tick(1'b1);
    chk("irq.set", 32'(vif_s.irq), 1);
    run_to(1, S_VSS + 1, 0, 1'b1);
    irq_en = 1'b0;
    tick(1'b0);
    chk("irq.clear_no_cen", 32'(vif_s.irq), 0);
    run_to(1, S_VT - 1, 0, 1'b1);
    irq_en = 1'b1;
    run_to(1, S_VBS - 1, S_HT - 1, 1'b1);
    chk("irq.no_reassert", 32'(vif_s.irq), 0);
    tick(1'b1);
    chk("irq.reassert", 32'(vif_s.irq), 1);

    // Clear wins over a same-cycle set.
    irq_en = 1'b0;
    tick(1'b0);
    irq_en = 1'b1;
    run_to(1, S_VBS - 1, S_HT - 1, 1'b1);
    irq_en = 1'b0;
    tick(1'b1);
    chk("prio.v", 32'(vif_s.vdump), S_VBS);
    chk("prio.irq", 32'(vif_s.irq), 0);
    irq_en = 1'b1;
    tick(1'b0);
    chk("prio.irq_after", 32'(vif_s.irq), 0);

    // Random pulses and enable toggling.
    repeat (1500) begin
      if ($urandom_range(0, 15) == 0) irq_en = ~irq_en;
      tick($urandom_range(0, 1) == 1);
    end

    // Mid-frame reset on the default instance.
    irq_en = 1'b1;
    run_to(0, 100, 50, 1'b0);
    rst = 1'b1;
    tick(1'b1);
    chk("midrst.hdump", 32'(vif_d.hdump), 0);
    chk("midrst.vdump", 32'(vif_d.vdump), 0);
    chk("midrst.irq_sml", 32'(vif_s.irq), 0);
    rst = 1'b0;
    tick(1'b0);
    slow_start("restart");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
